decode_queue: RTL
=================

// Module: decode_queue
// PURPOSE
//  Parametrised instruction queue with decode-on-enqueue for the control unit.
//  Buffers DEPTH fetched 32-bit instructions and pre-decodes each one into its CU start state.
//  Presents the head entry (instruction + state code) to the control unit over a valid/ready handshake.
//  Sits between instruction-memory fetch and the CU state machine; replaces the flat combinational encoder.
// PARAMETERS
//  DEPTH   4   queue entries; any value >= 2 (need not be a power of 2)
//  CODE_W  8   width of the CU state code; must be >= 7
//  CNT_W   $clog2(DEPTH+1)   occupancy counter width (localparam)
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-low reset
//  flush       in   1        synchronous queue clear (branch taken / exception)
//  in_valid    in   1        fetch offers in_instr
//  in_ready    out  1        queue can accept; = (count != DEPTH)
//  in_instr    in   32       fetched instruction word
//  out_valid   out  1        head entry present; = (count != 0)
//  out_ready   in   1        CU consumes head this cycle
//  out_instr   out  32       head instruction; 0 when empty
//  out_code    out  CODE_W   head CU start state; 0 when empty or undefined encoding
//  out_cond    out  1        head condition-field pass (see CONFIGURATION)
//  count       out  CNT_W    current occupancy
// BEHAVIOUR
//  - Reset (reset=0, async): count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1, out_instr=0, out_code=0, out_cond=0.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the rising edge of clk.
//  - Push writes {in_instr, decode(in_instr)} at wr_ptr. Pop advances rd_ptr. Both pointers wrap DEPTH-1 -> 0.
//  - Latency: an entry pushed at edge N is visible at the head at edge N+1 (out_valid rises after N). No same-cycle bypass.
//  - Simultaneous push+pop with 0<count<DEPTH: both happen and count is unchanged.
//  - When full, in_ready=0 even if out_ready=1, so a push is never accepted while full.
//  - When empty, out_ready is ignored and count never underflows.
//  - flush=1: at the next edge count=0 and pointers=0. Flush overrides a push and a pop in the same cycle.
//  - Reset asserted mid-operation discards all entries immediately; there is no partial state.
//  - out_* are driven from the storage registers at rd_ptr and are stable while out_valid=1 and out_ready=0.
//  - Decode (by [27:25]); unlisted or undefined encodings -> 0:
//     001 data-proc immediate, opcode [24:20] per CU state table: ADD 7, ADDS 12, CMP 8, MOV 9, MOVS 13, others per table.
//     000 & [4]=0: [24:20]=01000 -> ADD (5 if [11:5]=0, else 6); 01001 -> ADDS (10 / 11); other opcodes per table (CMP 55, MOV 56, MOVS 57).
//     000 & [7]=1 & [4]=1 (addressing mode 3): [24]=1 -> 25..28 by [22:21]; [24]=0 -> [22:21]=10 gives 29, 00 gives 30.
//     010: [24]=1 -> 31 ([21]=0) / 32 ([21]=1); [24]=0 -> 33.
//     011 & [4]=0: [24]=1 -> 34 / 35 by [21]; [24]=0 -> 36.
//     100 (addressing mode 4), [24:20] in {00000,00010,01000,...,11011} -> 65..80 in per-table order.
//     101: [24]=0 -> B 14; [24]=1 -> BL 15.
//  - Decode is a pure function of in_instr and is computed once, at push.
// CONFIGURATION
//  - DECODE_COND_EN defined:
//     - Adds input cond_flags[3:0] = {N,Z,C,V}.
//     - out_cond = ARM condition test of out_instr[31:28] against cond_flags, combinational from the head.
//     - Conditions EQ..LE are evaluated per the architecture. AL (1110) = 1; 1111 = 0.
//     - out_cond=0 when empty.
//  - DECODE_COND_EN undefined: no cond_flags port; out_cond = out_valid.
// TESTING
//  1. Reset low mid-stream with count=3 -> all outputs go to reset values at once; count=0, in_ready=1.
//  2. Push 0xEA000000, 0xE2811001, 0xE3A00005, 0xE5910000 with out_ready=0 ->
//     count=4, in_ready=0, and a 5th in_valid is not accepted.
//     Then pop 4 with out_ready=1 -> codes 14, 7, 9, 31 in that order.
//  3. DEPTH=3, count=2, push+pop for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
//  4. flush=1 together with in_valid=1 and out_ready=1 at count=2 -> next cycle count=0, out_valid=0, out_code=0.
//  5. DECODE_COND_EN, head 0x0A000000 (BEQ): flags=0000 -> out_cond=0; flags=0100 -> out_cond=1, out_code=14.
//  6. Push 0xE7F000F0 (undefined) -> out_code=0 and out_valid=1.

Source files
------------

// File: rtl/decode_queue.sv
// ----------------------------------------------------------------------------
// decode_queue
//   Instruction queue that pre-decodes each fetched word into its control-unit
//   start state as it is written. The control unit reads the head entry over
//   a valid/ready handshake. There is no bypass, so a word pushed at one edge
//   reaches the head at the following edge.
//
// Parameters
//   DEPTH   queue entries, any value >= 2 (need not be a power of two)
//   CODE_W  width of the CU state code, >= 7
//   CNT_W   occupancy counter width (derived)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous clear, wins over push and pop
//   in_valid   in   fetch offers in_instr
//   in_ready   out  queue not full
//   in_instr   in   fetched 32-bit instruction word
//   out_valid  out  queue not empty
//   out_ready  in   control unit consumes the head this cycle
//   out_instr  out  head instruction, 0 when empty
//   out_code   out  head CU start state, 0 when empty or undefined encoding
//   out_cond   out  head condition-field pass
//   count      out  current occupancy
//   cond_flags in   {N,Z,C,V}, present only when DECODE_COND_EN is defined
//
// Optional feature macro: DECODE_COND_EN
//   Defined   : out_cond is the ARM condition test of the head's [31:28]
//               against cond_flags (0 when empty).
//   Undefined : out_cond simply follows out_valid.
// ----------------------------------------------------------------------------
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [CODE_W-1:0] out_code,
    output logic              out_cond,
`ifdef DECODE_COND_EN
    input  logic [3:0]        cond_flags,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [6:0]        decCode;
    logic [31:0]       instrMem_q [DEPTH];
    logic [CODE_W-1:0] codeMem_q  [DEPTH];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake flags; the full/empty tests come straight from the counter.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Pre-decode of the incoming word into its CU start state. Every state
    // fits in 7 bits; anything not recognised decodes to 0.
    always_comb begin
        decCode = 7'd0;
        case (in_instr[27:25])
            3'b001: begin
                case (in_instr[24:20])
                    5'b01000: decCode = 7'd7;
                    5'b01001: decCode = 7'd12;
                    5'b10101: decCode = 7'd8;
                    5'b11010: decCode = 7'd9;
                    5'b11011: decCode = 7'd13;
                    default:  decCode = 7'd0;
                endcase
            end
            3'b000: begin
                if (!in_instr[4]) begin
                    case (in_instr[24:20])
                        5'b01000: decCode = (in_instr[11:5] == 7'd0) ? 7'd5 : 7'd6;
                        5'b01001: decCode = (in_instr[11:5] == 7'd0) ? 7'd10 : 7'd11;
                        5'b10101: decCode = 7'd55;
                        5'b11010: decCode = 7'd56;
                        5'b11011: decCode = 7'd57;
                        default:  decCode = 7'd0;
                    endcase
                end else if (in_instr[7]) begin
                    if (in_instr[24]) begin
                        decCode = 7'd25 + {5'd0, in_instr[22:21]};
                    end else if (in_instr[22:21] == 2'b10) begin
                        decCode = 7'd29;
                    end else if (in_instr[22:21] == 2'b00) begin
                        decCode = 7'd30;
                    end
                end
            end
            3'b010: begin
                decCode = in_instr[24] ? (7'd31 + {6'd0, in_instr[21]}) : 7'd33;
            end
            3'b011: begin
                if (!in_instr[4]) begin
                    decCode = in_instr[24] ? (7'd34 + {6'd0, in_instr[21]}) : 7'd36;
                end
            end
            3'b100: begin
                // Block transfers without the S bit; states are ordered
                // loads after stores, then by P, U, W.
                if (!in_instr[22]) begin
                    decCode = 7'd65 + {3'd0, in_instr[20], in_instr[24],
                                       in_instr[23], in_instr[21]};
                end
            end
            3'b101: begin
                decCode = in_instr[24] ? 7'd15 : 7'd14;
            end
            default: decCode = 7'd0;
        endcase
    end

    // Next-state for pointers and occupancy; flush clears everything.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control registers; reset drops every entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset because the outputs are masked while
    // the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem_q[wrPtr_q] <= in_instr;
            codeMem_q[wrPtr_q]  <= CODE_W'(decCode);
        end
    end

    // Head entry, forced to zero while the queue is empty.
    assign out_instr = out_valid ? instrMem_q[rdPtr_q] : '0;
    assign out_code  = out_valid ? codeMem_q[rdPtr_q] : '0;

`ifdef DECODE_COND_EN
    logic condBase;

    // Conditions come in complementary pairs: [31:29] picks the base test
    // and [28] inverts it. AL/1111 fall out as 1 and 0 from the same rule.
    always_comb begin
        condBase = 1'b0;
        case (out_instr[31:29])
            3'd0:    condBase = cond_flags[2];
            3'd1:    condBase = cond_flags[1];
            3'd2:    condBase = cond_flags[3];
            3'd3:    condBase = cond_flags[0];
            3'd4:    condBase = cond_flags[1] & ~cond_flags[2];
            3'd5:    condBase = (cond_flags[3] == cond_flags[0]);
            3'd6:    condBase = ~cond_flags[2] & (cond_flags[3] == cond_flags[0]);
            default: condBase = 1'b1;
        endcase
        out_cond = out_valid & (condBase ^ out_instr[28]);
    end
`else
    assign out_cond = out_valid;
`endif

endmodule
